clint_mh: RTL

Multi-hart Core Local Interrupt Controller for the siiCpu AHB-lite peripheral bus. It provides one shared 64-bit `mtime` counter plus per-hart `mtimecmp` and `msip` registers, and drives one timer and one software interrupt line per hart. It replaces the single-hart CLINT. Decoding is RISC-V CLINT compatible, timer compare is `>=`, and malformed accesses get a proper two-cycle AHB ERROR response.

---
 rtl/clint_mh_if.sv | 22 ++
 rtl/clint_mh.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clint_mh_if.sv
// AHB-lite slave bus bundle for clint_mh; the master modport is the bus side, slave is the CLINT.
interface clint_mh_if;
   logic        HSELx;
   logic        HWRITE;
   logic [31:0] HADDR;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic [1:0]  HRESP;

   modport master (
      output HSELx, HWRITE, HADDR, HSIZE, HTRANS, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HSELx, HWRITE, HADDR, HSIZE, HTRANS, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/clint_mh.sv
// Multi-hart CLINT: shared 64-bit mtime, per-hart mtimecmp/msip, level timer and software interrupts.
// Define CLINT_RTC_SYNC_EN to tick mtime from io_rtcToggle edges instead of the TICK_DIV prescaler.
module clint_mh #(
   parameter int          NUM_HARTS    = 2,
   parameter int          TICK_DIV     = 1,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 io_rtcToggle,
   clint_mh_if.slave            bus,
   output logic [NUM_HARTS-1:0] irq_timer,
   output logic [NUM_HARTS-1:0] irq_software
);

   typedef enum logic [1:0] {IDLE_OK, ERR1, ERR2} respState_e;
   typedef enum logic [2:0] {REG_MSIP, REG_CMPLO, REG_CMPHI, REG_MTLO, REG_MTHI} regKind_e;

   localparam logic [15:0] MSIP_END = 16'(4 * NUM_HARTS);
   localparam logic [15:0] CMP_END  = 16'(16'h4000 + 8 * NUM_HARTS);

   respState_e           state_q, state_d;
   logic [31:0]          hrdata_q, hrdata_d;
   logic                 wrPend_q, wrPend_d;
   regKind_e             wrKind_q, wrKind_d;
   logic [2:0]           wrHart_q, wrHart_d;
   logic [63:0]          mtime_q, mtime_d;
   logic [63:0]          mtimecmp_q [NUM_HARTS];
   logic [63:0]          mtimecmp_d [NUM_HARTS];
   logic [NUM_HARTS-1:0] msip_q, msip_d;
   logic [NUM_HARTS-1:0] irqTimer_q, irqTimer_d;
   logic [NUM_HARTS-1:0] irqSoft_q;

   logic [15:0] offset;
   regKind_e    decKind;
   logic [2:0]  decHart;
   logic        decHit;
   logic        addrPhase;
   logic        accValid;
   logic        accInvalid;
   logic [31:0] regRdata;
   logic [31:0] fwdData;
   logic        fwdHit;
   logic        mtimeWr;
   logic        tick;

   // Address decode: anything outside the populated hart range is a miss and earns an ERROR
   always_comb begin
      offset  = bus.HADDR[15:0];
      decKind = REG_MSIP;
      decHart = 3'd0;
      decHit  = 1'b0;
      if (offset < MSIP_END) begin
         decKind = REG_MSIP;
         decHart = offset[4:2];
         decHit  = 1'b1;
      end else if (offset >= 16'h4000 && offset < CMP_END) begin
         decKind = offset[2] ? REG_CMPHI : REG_CMPLO;
         decHart = offset[5:3];
         decHit  = 1'b1;
      end else if (offset == 16'hBFF8) begin
         decKind = REG_MTLO;
         decHit  = 1'b1;
      end else if (offset == 16'hBFFC) begin
         decKind = REG_MTHI;
         decHit  = 1'b1;
      end
   end

   assign addrPhase  = bus.HSELx && bus.HTRANS[1] && (state_q != ERR1);
   assign accValid   = addrPhase && decHit && (bus.HSIZE == 3'b010) && (bus.HADDR[1:0] == 2'b00);
   assign accInvalid = addrPhase && !accValid;

   always_comb begin
      regRdata = '0;
      case (decKind)
         REG_MSIP: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (decHart == 3'(h)) regRdata = {31'b0, msip_q[h]};
         end
         REG_CMPLO: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (decHart == 3'(h)) regRdata = mtimecmp_q[h][31:0];
         end
         REG_CMPHI: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (decHart == 3'(h)) regRdata = mtimecmp_q[h][63:32];
         end
         REG_MTLO: regRdata = mtime_q[31:0];
         REG_MTHI: regRdata = mtime_q[63:32];
         default:  regRdata = '0;
      endcase
   end

   // A read hitting the register whose write data is on the bus right now returns that data
   assign fwdHit   = wrPend_q && (wrKind_q == decKind) && (wrHart_q == decHart);
   assign fwdData  = (decKind == REG_MSIP) ? {31'b0, bus.HWDATA[0]} : bus.HWDATA;
   assign hrdata_d = (accValid && !bus.HWRITE) ? (fwdHit ? fwdData : regRdata) : '0;

   assign wrPend_d = accValid && bus.HWRITE;
   assign wrKind_d = decKind;
   assign wrHart_d = decHart;

   always_comb begin
      state_d    = state_q;
      bus.HREADY = 1'b1;
      bus.HRESP  = 2'b00;
      case (state_q)
         IDLE_OK: state_d = accInvalid ? ERR1 : IDLE_OK;
         ERR1: begin
            state_d    = ERR2;
            bus.HREADY = 1'b0;
            bus.HRESP  = 2'b01;
         end
         ERR2: begin
            state_d   = accInvalid ? ERR1 : IDLE_OK;
            bus.HRESP = 2'b01;
         end
         default: state_d = IDLE_OK;
      endcase
   end

   // Register writes land at the end of the data phase; an mtime write overrides that cycle's tick
   always_comb begin
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      mtimeWr    = 1'b0;
      if (wrPend_q) begin
         case (wrKind_q)
            REG_MSIP: begin
               for (int h = 0; h < NUM_HARTS; h++)
                  if (wrHart_q == 3'(h)) msip_d[h] = bus.HWDATA[0];
            end
            REG_CMPLO: begin
               for (int h = 0; h < NUM_HARTS; h++)
                  if (wrHart_q == 3'(h)) mtimecmp_d[h][31:0] = bus.HWDATA;
            end
            REG_CMPHI: begin
               for (int h = 0; h < NUM_HARTS; h++)
                  if (wrHart_q == 3'(h)) mtimecmp_d[h][63:32] = bus.HWDATA;
            end
            REG_MTLO: begin
               mtime_d = {mtime_q[63:32], bus.HWDATA};
               mtimeWr = 1'b1;
            end
            REG_MTHI: begin
               mtime_d = {bus.HWDATA, mtime_q[31:0]};
               mtimeWr = 1'b1;
            end
            default: mtimeWr = 1'b0;
         endcase
      end
      for (int h = 0; h < NUM_HARTS; h++)
         irqTimer_d[h] = (mtime_q >= mtimecmp_q[h]);
   end

`ifdef CLINT_RTC_SYNC_EN
   logic rtcSync1_q, rtcSync2_q, rtcPrev_q;
   logic unusedBits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rtcSync1_q <= 1'b0;
         rtcSync2_q <= 1'b0;
         rtcPrev_q  <= 1'b0;
      end else begin
         rtcSync1_q <= io_rtcToggle;
         rtcSync2_q <= rtcSync1_q;
         rtcPrev_q  <= rtcSync2_q;
      end
   end

   assign tick       = rtcSync2_q & ~rtcPrev_q;
   assign unusedBits = ^{bus.HADDR[31:16], bus.HTRANS[0], mtimeWr};
`else
   localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
   logic [15:0] presc_q, presc_d;
   logic        unusedBits;

   // Restarting the prescaler on an mtime write gives software a full tick period after it sets time
   assign tick    = (presc_q == PRESC_LAST);
   assign presc_d = (mtimeWr || tick) ? 16'd0 : presc_q + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) presc_q <= 16'd0;
      else     presc_q <= presc_d;
   end

   assign unusedBits = ^{bus.HADDR[31:16], bus.HTRANS[0], io_rtcToggle};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE_OK;
         hrdata_q   <= '0;
         wrPend_q   <= 1'b0;
         wrKind_q   <= REG_MSIP;
         wrHart_q   <= 3'd0;
         mtime_q    <= '0;
         msip_q     <= '0;
         irqTimer_q <= '0;
         irqSoft_q  <= '0;
         for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= MTIMECMP_RST;
      end else begin
         state_q    <= state_d;
         hrdata_q   <= hrdata_d;
         wrPend_q   <= wrPend_d;
         wrKind_q   <= wrKind_d;
         wrHart_q   <= wrHart_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         irqTimer_q <= irqTimer_d;
         irqSoft_q  <= msip_q;
      end
   end

   assign bus.HRDATA   = hrdata_q;
   assign irq_timer    = irqTimer_q;
   assign irq_software = irqSoft_q;

endmodule
